// File: rtl/counter_updn_mod.sv
// counter_updn_mod: parametrised up/down modulo counter.
//   WIDTH-bit count with run-time direction, parallel load (clamped to MAX_VAL),
//   wrap or saturate at the boundaries, a terminal-count strike and sticky
//   overflow/underflow flags.
//
// Parameters
//   WIDTH    counter width in bits (>= 2)
//   MAX_VAL  terminal (top) count, 1 .. 2**WIDTH-1
//   WRAP     1: wrap at boundaries, 0: saturate at boundaries
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active-high, dominates everything
//   en        in   count enable, one step per cycle
//   dir       in   1 = up, 0 = down (sampled with en)
//   load      in   parallel load strobe (beats en)
//   load_val  in   value to load, clamped to MAX_VAL
//   flag_clr  in   clears ovf/udf; a coincident boundary event wins
//   cnt       out  current count, registered
//   tc        out  terminal-count strike, combinational
//   ovf       out  sticky: up-step taken at MAX_VAL
//   udf       out  sticky: down-step taken at 0
//
// Optional build macro CNT_UPDN_ASSERTS_EN compiles in an embedded SVA checker
// with a matching cover per assertion. Behaviour is identical either way.

module counter_updn_mod #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = (2 ** WIDTH) - 1,
  parameter int unsigned WRAP    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  // Largest value representable in WIDTH bits, computed wide to avoid overflow.
  localparam longint unsigned CNT_TOP = (64'd1 << WIDTH) - 64'd1;
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_V = '0;
  localparam bit               WRAP_B = (WRAP != 0);

  // Elaboration-time parameter checks.
  if (WIDTH < 2) begin : g_bad_width
    $error("counter_updn_mod: WIDTH must be >= 2");
  end
  if (MAX_VAL == 0) begin : g_bad_max_zero
    $error("counter_updn_mod: MAX_VAL must be >= 1");
  end
  if (64'(MAX_VAL) > CNT_TOP) begin : g_bad_max_range
    $error("counter_updn_mod: MAX_VAL exceeds 2**WIDTH-1");
  end

  logic             at_max;
  logic             at_zero;
  logic             step_ok;
  logic             up_evt;
  logic             dn_evt;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             udf_nxt;

  // Boundary detection; load masks any step, so it also masks boundary events.
  always_comb begin
    at_max  = (cnt == MAX_V);
    at_zero = (cnt == ZERO_V);
    step_ok = en & ~load;
    up_evt  = step_ok &  dir & at_max;
    dn_evt  = step_ok & ~dir & at_zero;
  end

  // Terminal-count strike is forced low while reset is asserted.
  assign tc = ~rst & (up_evt | dn_evt);

  // Next-count selection: load > step > hold.
  always_comb begin
    load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
    cnt_nxt      = cnt;
    if (load) begin
      cnt_nxt = load_clamped;
    end else if (en) begin
      if (dir) begin
        if (at_max) begin
          cnt_nxt = WRAP_B ? ZERO_V : MAX_V;
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          cnt_nxt = WRAP_B ? MAX_V : ZERO_V;
        end else begin
          cnt_nxt = cnt - WIDTH'(1);
        end
      end
    end
  end

  // Sticky flags: a boundary event in the same cycle beats flag_clr.
  always_comb begin
    ovf_nxt = (ovf & ~flag_clr) | up_evt;
    udf_nxt = (udf & ~flag_clr) | dn_evt;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      udf <= udf_nxt;
    end
  end

`ifdef CNT_UPDN_ASSERTS_EN
  // Embedded checker: each property is asserted and covered.
  property p_step_up;
    @(posedge clk) disable iff (rst)
      (en && !load && dir && (cnt < MAX_V)) |=> (cnt == $past(cnt) + WIDTH'(1));
  endproperty

  property p_step_dn;
    @(posedge clk) disable iff (rst)
      (en && !load && !dir && (cnt > ZERO_V)) |=> (cnt == $past(cnt) - WIDTH'(1));
  endproperty

  property p_hold;
    @(posedge clk) disable iff (rst)
      (!en && !load) |=> $stable(cnt);
  endproperty

  property p_range;
    @(posedge clk) disable iff (rst)
      (cnt <= MAX_V);
  endproperty

  property p_known;
    @(posedge clk) disable iff (rst)
      !$isunknown(cnt);
  endproperty

  property p_wrap_up;
    @(posedge clk) disable iff (rst)
      (en && !load && dir && (cnt == MAX_V)) |=> (cnt == (WRAP_B ? ZERO_V : MAX_V));
  endproperty

  property p_wrap_dn;
    @(posedge clk) disable iff (rst)
      (en && !load && !dir && (cnt == ZERO_V)) |=> (cnt == (WRAP_B ? MAX_V : ZERO_V));
  endproperty

  property p_sticky_ovf;
    @(posedge clk) disable iff (rst)
      (ovf && !flag_clr) |=> ovf;
  endproperty

  property p_sticky_udf;
    @(posedge clk) disable iff (rst)
      (udf && !flag_clr) |=> udf;
  endproperty

  a_step_up: assert property (p_step_up)
    else $display("assertion step_up failed at %0t", $time);
  a_step_dn: assert property (p_step_dn)
    else $display("assertion step_dn failed at %0t", $time);
  a_hold: assert property (p_hold)
    else $display("assertion hold failed at %0t", $time);
  a_range: assert property (p_range)
    else $display("assertion range failed at %0t", $time);
  a_known: assert property (p_known)
    else $display("assertion known failed at %0t", $time);
  a_wrap_up: assert property (p_wrap_up)
    else $display("assertion wrap_up failed at %0t", $time);
  a_wrap_dn: assert property (p_wrap_dn)
    else $display("assertion wrap_dn failed at %0t", $time);
  a_sticky_ovf: assert property (p_sticky_ovf)
    else $display("assertion sticky_ovf failed at %0t", $time);
  a_sticky_udf: assert property (p_sticky_udf)
    else $display("assertion sticky_udf failed at %0t", $time);

  c_step_up:    cover property (p_step_up);
  c_step_dn:    cover property (p_step_dn);
  c_hold:       cover property (p_hold);
  c_range:      cover property (p_range);
  c_known:      cover property (p_known);
  c_wrap_up:    cover property (p_wrap_up);
  c_wrap_dn:    cover property (p_wrap_dn);
  c_sticky_ovf: cover property (p_sticky_ovf);
  c_sticky_udf: cover property (p_sticky_udf);
`endif

endmodule

// File: tb/tb_counter_updn_mod.sv
// Directed bench for counter_updn_mod: three instances share the control inputs
// (WIDTH=4/MAX_VAL=9 wrap, WIDTH=4/MAX_VAL=9 saturate, defaults) and each
// scenario task checks the instance it exercises against hand-computed values.

module tb_counter_updn_mod;

  logic       clk;
  logic       rst;
  logic       en;
  logic       dir;
  logic       load;
  logic [7:0] load_val;
  logic       flag_clr;

  logic [3:0] cnt_a;
  logic       tc_a, ovf_a, udf_a;
  logic [3:0] cnt_s;
  logic       tc_s, ovf_s, udf_s;
  logic [7:0] cnt_d;
  logic       tc_d, ovf_d, udf_d;

  int total;
  int bad;

  counter_updn_mod #(.WIDTH(4), .MAX_VAL(9), .WRAP(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_val(load_val[3:0]), .flag_clr(flag_clr),
    .cnt(cnt_a), .tc(tc_a), .ovf(ovf_a), .udf(udf_a)
  );

  counter_updn_mod #(.WIDTH(4), .MAX_VAL(9), .WRAP(0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_val(load_val[3:0]), .flag_clr(flag_clr),
    .cnt(cnt_s), .tc(tc_s), .ovf(ovf_s), .udf(udf_s)
  );

  counter_updn_mod dut_d (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .flag_clr(flag_clr),
    .cnt(cnt_d), .tc(tc_d), .ovf(ovf_d), .udf(udf_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and land 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; dir = 1'b0; load = 1'b0; load_val = 8'd0; flag_clr = 1'b0;
    #1;
    total++; if (tc_a !== 1'b0) begin bad++; $display("FAIL reset_tc: got %b want 0", tc_a); end
    tick();
    total++; if (cnt_a !== 4'd0) begin bad++; $display("FAIL reset_cnt_a: got %0d want 0", cnt_a); end
    total++; if (ovf_a !== 1'b0 || udf_a !== 1'b0) begin bad++; $display("FAIL reset_flags_a: got ovf=%b udf=%b want 0 0", ovf_a, udf_a); end
    total++; if (cnt_s !== 4'd0) begin bad++; $display("FAIL reset_cnt_s: got %0d want 0", cnt_s); end
    total++; if (cnt_d !== 8'd0) begin bad++; $display("FAIL reset_cnt_d: got %0d want 0", cnt_d); end
    total++; if (tc_a !== 1'b0) begin bad++; $display("FAIL reset_tc_hold: got %b want 0", tc_a); end
    rst = 1'b0; en = 1'b0;
  endtask

  task automatic test_count_wrap();
    en = 1'b1; dir = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      total++; if (cnt_a !== 4'(i % 10)) begin bad++; $display("FAIL wrap_cnt[%0d]: got %0d want %0d", i, cnt_a, i % 10); end
      total++; if (tc_a !== ((i % 10) == 9)) begin bad++; $display("FAIL wrap_tc[%0d]: got %b want %b", i, tc_a, (i % 10) == 9); end
      tick();
      total++; if (ovf_a !== (i >= 9)) begin bad++; $display("FAIL wrap_ovf[%0d]: got %b want %b", i, ovf_a, i >= 9); end
    end
    total++; if (udf_a !== 1'b0) begin bad++; $display("FAIL wrap_udf: got %b want 0", udf_a); end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    load = 1'b1; load_val = 8'd2;
    tick();
    total++; if (cnt_s !== 4'd2) begin bad++; $display("FAIL sat_load: got %0d want 2", cnt_s); end
    load = 1'b0; en = 1'b1; dir = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (tc_s !== (i >= 2)) begin bad++; $display("FAIL sat_dn_tc[%0d]: got %b want %b", i, tc_s, i >= 2); end
      tick();
      total++; if (cnt_s !== ((i == 0) ? 4'd1 : 4'd0)) begin bad++; $display("FAIL sat_dn_cnt[%0d]: got %0d want %0d", i, cnt_s, (i == 0) ? 1 : 0); end
      total++; if (udf_s !== (i >= 2)) begin bad++; $display("FAIL sat_dn_udf[%0d]: got %b want %b", i, udf_s, i >= 2); end
    end
    en = 1'b0; flag_clr = 1'b1;
    tick();
    total++; if (ovf_s !== 1'b0 || udf_s !== 1'b0) begin bad++; $display("FAIL sat_clr: got ovf=%b udf=%b want 0 0", ovf_s, udf_s); end
    flag_clr = 1'b0; load = 1'b1; load_val = 8'd9;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    #1;
    total++; if (tc_s !== 1'b1) begin bad++; $display("FAIL sat_up_tc: got %b want 1", tc_s); end
    tick();
    total++; if (cnt_s !== 4'd9) begin bad++; $display("FAIL sat_up_cnt: got %0d want 9", cnt_s); end
    total++; if (ovf_s !== 1'b1) begin bad++; $display("FAIL sat_up_ovf: got %b want 1", ovf_s); end
    en = 1'b0;
  endtask

  task automatic test_load();
    load = 1'b1; load_val = 8'd15; en = 1'b0;
    tick();
    total++; if (cnt_a !== 4'd9) begin bad++; $display("FAIL load_clamp: got %0d want 9", cnt_a); end
    load = 1'b0; flag_clr = 1'b1;
    tick();
    total++; if (ovf_a !== 1'b0 || udf_a !== 1'b0) begin bad++; $display("FAIL load_preclr: got ovf=%b udf=%b want 0 0", ovf_a, udf_a); end
    total++; if (cnt_a !== 4'd9) begin bad++; $display("FAIL load_hold_clr: got %0d want 9", cnt_a); end
    flag_clr = 1'b0; load = 1'b1; load_val = 8'd3; en = 1'b1; dir = 1'b1;
    #1;
    total++; if (tc_a !== 1'b0) begin bad++; $display("FAIL load_en_tc: got %b want 0", tc_a); end
    tick();
    total++; if (cnt_a !== 4'd3) begin bad++; $display("FAIL load_en_cnt: got %0d want 3", cnt_a); end
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL load_en_ovf: got %b want 0", ovf_a); end
    load = 1'b0; en = 1'b0;
    tick();
    tick();
    total++; if (cnt_a !== 4'd3) begin bad++; $display("FAIL hold: got %0d want 3", cnt_a); end
  endtask

  task automatic test_flag_clr();
    load = 1'b1; load_val = 8'd9;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    tick();
    total++; if (cnt_a !== 4'd0 || ovf_a !== 1'b1) begin bad++; $display("FAIL clr_setup: got cnt=%0d ovf=%b want 0 1", cnt_a, ovf_a); end
    en = 1'b0; flag_clr = 1'b1;
    tick();
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL clr_plain: got %b want 0", ovf_a); end
    flag_clr = 1'b0; load = 1'b1; load_val = 8'd9;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b1; flag_clr = 1'b1;
    tick();
    total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL clr_vs_set: got %b want 1", ovf_a); end
    total++; if (cnt_a !== 4'd0) begin bad++; $display("FAIL clr_vs_set_cnt: got %0d want 0", cnt_a); end
    flag_clr = 1'b0; dir = 1'b0;
    tick();
    total++; if (cnt_a !== 4'd9 || udf_a !== 1'b1) begin bad++; $display("FAIL udf_wrap: got cnt=%0d udf=%b want 9 1", cnt_a, udf_a); end
    en = 1'b0; flag_clr = 1'b1;
    tick();
    total++; if (udf_a !== 1'b0 || ovf_a !== 1'b0 || cnt_a !== 4'd9) begin bad++; $display("FAIL udf_clr: got cnt=%0d ovf=%b udf=%b want 9 0 0", cnt_a, ovf_a, udf_a); end
    flag_clr = 1'b0;
  endtask

  task automatic test_mid_reset();
    load = 1'b1; load_val = 8'd9;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    tick();
    en = 1'b0; load = 1'b1; load_val = 8'd5;
    tick();
    total++; if (cnt_a !== 4'd5 || ovf_a !== 1'b1) begin bad++; $display("FAIL mid_setup: got cnt=%0d ovf=%b want 5 1", cnt_a, ovf_a); end
    load = 1'b0; en = 1'b1; dir = 1'b1; rst = 1'b1;
    tick();
    total++; if (cnt_a !== 4'd0 || ovf_a !== 1'b0 || udf_a !== 1'b0) begin bad++; $display("FAIL mid_rst: got cnt=%0d ovf=%b udf=%b want 0 0 0", cnt_a, ovf_a, udf_a); end
    rst = 1'b0;
    tick();
    total++; if (cnt_a !== 4'd1) begin bad++; $display("FAIL mid_resume1: got %0d want 1", cnt_a); end
    tick();
    total++; if (cnt_a !== 4'd2) begin bad++; $display("FAIL mid_resume2: got %0d want 2", cnt_a); end
    en = 1'b0;
  endtask

  task automatic test_dir_toggle();
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dir = ((i % 2) == 1);
      #1;
      total++; if (tc_d !== 1'b1) begin bad++; $display("FAIL tog_tc[%0d]: got %b want 1", i, tc_d); end
      tick();
      total++; if (cnt_d !== (((i % 2) == 1) ? 8'd0 : 8'd255)) begin bad++; $display("FAIL tog_cnt[%0d]: got %0d want %0d", i, cnt_d, ((i % 2) == 1) ? 0 : 255); end
    end
    total++; if (ovf_d !== 1'b1 || udf_d !== 1'b1) begin bad++; $display("FAIL tog_flags: got ovf=%b udf=%b want 1 1", ovf_d, udf_d); end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    load = 1'b1; load_val = 8'd254;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    #1;
    total++; if (tc_d !== 1'b0) begin bad++; $display("FAIL b2b_tc0: got %b want 0", tc_d); end
    tick();
    total++; if (cnt_d !== 8'd255 || tc_d !== 1'b1) begin bad++; $display("FAIL b2b_top: got cnt=%0d tc=%b want 255 1", cnt_d, tc_d); end
    tick();
    total++; if (cnt_d !== 8'd0) begin bad++; $display("FAIL b2b_wrap: got %0d want 0", cnt_d); end
    en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_count_wrap();
    test_saturate();
    test_load();
    test_flag_clr();
    test_mid_reset();
    test_dir_toggle();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
